// File: rtl/sha3_pkg.sv
// Shared types for the SHA3 message sequencer.
// State encoding and padder geometry.
package sha3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    TAIL,
    WACK,
    WPERM,
    DONE
  } state_e;

  localparam int RATE_WORDS = 9;
  localparam int WORD_W     = 64;

endpackage

// File: rtl/sha3_msg_sched.sv
// Feeds host words into the SHA3 padder, sequences the
// permutation handshake and captures the final digest.
import sha3_pkg::*;

module sha3_msg_sched #(
  parameter int LEN_W   = 32,
  parameter int HASH_W  = 512,
  parameter int RST_CYC = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [LEN_W-1:0]  iLen,
  input  logic [63:0]       iData,
  input  logic              iValid,
  output logic              oReady,
  output logic              oCoreRst,
  output logic [63:0]       oPadData,
  output logic              oPadReady,
  output logic              oPadLast,
  output logic [2:0]        oPadByteNum,
  input  logic              iPadFull,
  input  logic              iPadAck,
  input  logic              iPermDone,
  input  logic [HASH_W-1:0] iHash,
  output logic [HASH_W-1:0] oHash,
  output logic              oDone,
  output logic              oBusy
);

  localparam int REM_W = LEN_W - 3;
  localparam int CNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_e             r_state;
  state_e             w_next;
  logic [REM_W-1:0]   r_full_rem;
  logic [2:0]         r_tail;
  logic [CNT_W-1:0]   r_clr_cnt;
  logic [HASH_W-1:0]  r_hash;

  logic               w_idle_like;
  logic               w_clr_done;
  logic               w_take;
  logic               w_ready;
  logic               w_pad_ready;
  logic               w_pad_last;
  logic [63:0]        w_pad_data;
  logic [2:0]         w_pad_bn;

  assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
  assign w_clr_done  = (r_clr_cnt == CNT_W'(RST_CYC - 1));
  assign w_take      = w_pad_ready;

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (iStart) w_next = CLR;
      CLR: begin
        if (w_clr_done)
          w_next = (r_full_rem != '0) ? LOAD : TAIL;
      end
      LOAD: begin
        if (w_take && r_full_rem == REM_W'(1))
          w_next = TAIL;
      end
      TAIL:  if (w_take)     w_next = WACK;
      WACK:  if (iPadAck)    w_next = WPERM;
      WPERM: if (iPermDone)  w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Pad-side strobes are combinational so the padder sees them with no lag
  always_comb begin
    w_ready     = 1'b0;
    w_pad_ready = 1'b0;
    w_pad_last  = 1'b0;
    w_pad_data  = '0;
    w_pad_bn    = '0;
    unique case (r_state)
      LOAD: begin
        w_ready     = ~iPadFull;
        w_pad_ready = iValid & ~iPadFull;
        w_pad_data  = iData;
      end
      TAIL: begin
        if (r_tail != 3'd0) begin
          w_ready     = ~iPadFull;
          w_pad_ready = iValid & ~iPadFull;
          w_pad_last  = iValid & ~iPadFull;
          w_pad_data  = iData;
          w_pad_bn    = r_tail;
        end else begin
          w_pad_ready = ~iPadFull;
          w_pad_last  = ~iPadFull;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_full_rem <= '0;
      r_tail     <= '0;
      r_clr_cnt  <= '0;
      r_hash     <= '0;
    end else begin
      if (w_idle_like && iStart) begin
        r_full_rem <= iLen[LEN_W-1:3];
        r_tail     <= iLen[2:0];
        r_clr_cnt  <= '0;
      end
      if (r_state == CLR)
        r_clr_cnt <= r_clr_cnt + CNT_W'(1);
      if (r_state == LOAD && w_take)
        r_full_rem <= r_full_rem - REM_W'(1);
      if (r_state == WPERM && iPermDone)
        r_hash <= iHash;
    end
  end

  assign oReady      = w_ready;
  assign oPadReady   = w_pad_ready;
  assign oPadLast    = w_pad_last;
  assign oPadData    = w_pad_data;
  assign oPadByteNum = w_pad_bn;
  assign oCoreRst    = iRst | (r_state == CLR);
  assign oHash       = r_hash;
  assign oDone       = (r_state == DONE);
  assign oBusy       = ~w_idle_like;

endmodule
